// File: rtl/shifter_pipe.sv
// Pipelined log-structured barrel shifter (SLL/SRL/SRA/ROL) with valid/ready
// handshaking; all stages advance together and hold as a unit under backpressure.
module shifter_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int STAGES     = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [1:0]                    in_op,
    input  logic [$clog2(DATA_WIDTH)-1:0] in_shamt,
    input  logic [DATA_WIDTH-1:0]         in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          busy
);

    localparam int SHW    = $clog2(DATA_WIDTH);
    localparam int LEVELS = SHW;
    localparam int LPS    = (LEVELS + STAGES - 1) / STAGES;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;

    // One mux level: shift by a fixed power of two; SRA keeps the MSB, which
    // therefore still holds the original sign bit at every later level.
    function automatic logic [DATA_WIDTH-1:0] shift_level(
        input logic [DATA_WIDTH-1:0] d,
        input logic [1:0]            op,
        input int                    amt
    );
        logic signed [DATA_WIDTH-1:0] ds;
        ds = d;
        case (op)
            OP_SLL:  shift_level = d << amt;
            OP_SRL:  shift_level = d >> amt;
            OP_SRA:  shift_level = ds >>> amt;
            default: shift_level = (d << amt) | (d >> (DATA_WIDTH - amt));
        endcase
    endfunction

    // Index 0 of each array is the stage-0 input; index s+1 is stage s's register.
    logic [DATA_WIDTH-1:0] data_p  [0:STAGES];
    logic [1:0]            op_p    [0:STAGES-1];
    logic [SHW-1:0]        shamt_p [0:STAGES-1];
    logic [STAGES-1:0]     vld_p;
    logic                  adv;

    assign data_p[0]  = in_data;
    assign op_p[0]    = in_op;
    assign shamt_p[0] = in_shamt;

    assign adv       = !vld_p[STAGES-1] || out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_p[STAGES-1];
    assign out_data  = data_p[STAGES];
    assign busy      = |vld_p;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        logic [DATA_WIDTH-1:0] lvl [0:LPS];
        logic [DATA_WIDTH-1:0] data_q;
        logic                  vld_q;
        logic                  vld_in;

        assign lvl[0] = data_p[s];

        for (genvar k = 0; k < LPS; k++) begin : g_lvl
            localparam int J = s * LPS + k;
            if (J < LEVELS) begin : g_mux
                assign lvl[k+1] = shamt_p[s][J] ? shift_level(lvl[k], op_p[s], 1 << J) : lvl[k];
            end else begin : g_pass
                assign lvl[k+1] = lvl[k];
            end
        end

        if (s == 0) begin : g_vin0
            assign vld_in = in_valid;
        end else begin : g_vinn
            assign vld_in = vld_p[s-1];
        end

        // ---- stage s register boundary ----
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q <= 1'b0;
            end else if (adv) begin
                vld_q <= vld_in;
            end
        end
        assign vld_p[s] = vld_q;

        if (s == STAGES - 1) begin : g_last
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    data_q <= '0;
                end else if (adv) begin
                    data_q <= lvl[LPS];
                end
            end
        end else begin : g_mid
            logic [1:0]     op_q;
            logic [SHW-1:0] shamt_q;
            always_ff @(posedge clk) begin
                if (adv) begin
                    data_q  <= lvl[LPS];
                    op_q    <= op_p[s];
                    shamt_q <= shamt_p[s];
                end
            end
            assign op_p[s+1]    = op_q;
            assign shamt_p[s+1] = shamt_q;
        end

        assign data_p[s+1] = data_q;
    end

endmodule
